// File: rtl/clk_div_bank.sv
// clk_div_bank
// Multi-channel programmable frequency divider. Each channel produces a
// one-cycle tick (clock enable) every d cycles and a 50%-duty square wave
// that toggles on every tick. Divisors are writable at runtime through a
// shared write port, and a common sync restarts every channel in phase.
//
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   en      per-channel count enable
//   sync    restart all channel counters together, square waves cleared
//   wr_en   divisor write strobe
//   wr_ch   channel index for divisor write (out-of-range indices ignored)
//   wr_div  new divisor value (0 behaves as 1)
//   tick    registered one-cycle pulse per channel period
//   sq      registered square wave, toggles on each tick
//   div_rd  current divisor registers, channel i at [i*CNT_W +: CNT_W]
//
// All outputs come straight from flops; use them as clock enables rather
// than routing sq onto clock nets.

module clk_div_bank #(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 25,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {25'd300001, 25'd2},
  parameter int                      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      sync,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         sq,
  output logic [NUM_CH*CNT_W-1:0]   div_rd
);

  // Terminal count for a divisor: d-1, with a zero divisor treated as 1.
  // Computing d-1 directly keeps the compare inside CNT_W bits, so the
  // largest divisor (all ones) cannot overflow.
  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] div_val);
    if (div_val == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return div_val - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             tick_ff;
    logic             sq_ff;
    logic             wr_sel;

    // Index compare only matches real channels, so an out-of-range wr_ch
    // selects nothing.
    assign wr_sel = wr_en && (wr_ch == CH_W'(g));

    // Per-channel divisor, counter, tick and square-wave state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt     <= {CNT_W{1'b0}};
        div     <= DIV_INIT[g*CNT_W +: CNT_W];
        tick_ff <= 1'b0;
        sq_ff   <= 1'b0;
      end else if (wr_sel) begin
        // Write wins over sync; the square wave keeps its level.
        div     <= wr_div;
        cnt     <= {CNT_W{1'b0}};
        tick_ff <= 1'b0;
      end else if (sync) begin
        cnt     <= {CNT_W{1'b0}};
        tick_ff <= 1'b0;
        sq_ff   <= 1'b0;
      end else if (!en[g]) begin
        tick_ff <= 1'b0;
      end else if (cnt >= last_count(div)) begin
        // >= rather than == so a corrupted counter still wraps at once.
        cnt     <= {CNT_W{1'b0}};
        tick_ff <= 1'b1;
        sq_ff   <= ~sq_ff;
      end else begin
        cnt     <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        tick_ff <= 1'b0;
      end
    end

    assign tick[g]                   = tick_ff;
    assign sq[g]                     = sq_ff;
    assign div_rd[g*CNT_W +: CNT_W]  = div;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
// Self-checking bench for clk_div_bank. A countdown reference model is
// advanced each time stimulus is applied; its expected outputs are pushed
// to a scoreboard queue and popped when the DUT outputs are sampled one
// time unit after the following rising edge. Directed checks on tick
// latencies and divisor values sit on top of the scoreboard. A second,
// three-channel instance exercises the out-of-range write index.

module tb_clk_div_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 25;
  localparam logic [49:0] INIT = {25'd300001, 25'd2};
  localparam logic [23:0] INIT3 = {8'd4, 8'd3, 8'd2};

  logic              clk;
  logic              reset;
  logic [1:0]        en;
  logic              sync;
  logic              wr_en;
  logic [0:0]        wr_ch;
  logic [24:0]       wr_div;
  logic [1:0]        tick;
  logic [1:0]        sq;
  logic [49:0]       div_rd;

  logic [2:0]        en3;
  logic              sync3;
  logic              wr_en3;
  logic [1:0]        wr_ch3;
  logic [7:0]        wr_div3;
  logic [2:0]        tick3;
  logic [2:0]        sq3;
  logic [23:0]       div_rd3;

  clk_div_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(INIT), .CH_W(1)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .tick(tick), .sq(sq), .div_rd(div_rd)
  );

  clk_div_bank #(
    .NUM_CH(3), .CNT_W(8), .DIV_INIT(INIT3), .CH_W(2)
  ) u_dut3 (
    .clk(clk), .reset(reset), .en(en3), .sync(sync3), .wr_en(wr_en3),
    .wr_ch(wr_ch3), .wr_div(wr_div3), .tick(tick3), .sq(sq3), .div_rd(div_rd3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  string phase = "init";

  // Count one comparison and report it when it disagrees.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  // Reference model: cycles remaining until the next tick per channel.
  typedef struct {
    logic [1:0]  tick;
    logic [1:0]  sq;
    logic [49:0] div;
  } exp_t;

  exp_t        sb[$];
  logic [24:0] mdiv [2];
  longint      rem  [2];
  logic [1:0]  mtick;
  logic [1:0]  msq;

  function automatic longint eff(input logic [24:0] d);
    return (d == 25'd0) ? 64'd1 : longint'(d);
  endfunction

  task automatic model_reset();
    mdiv[0] = INIT[24:0];
    mdiv[1] = INIT[49:25];
    for (int c = 0; c < 2; c++) rem[c] = eff(mdiv[c]);
    mtick = 2'b00;
    msq   = 2'b00;
  endtask

  // Advance the model by one edge using the inputs now driven.
  task automatic model_step();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (wr_en && (int'(wr_ch) == c)) begin
        mdiv[c]  = wr_div;
        rem[c]   = eff(wr_div);
        mtick[c] = 1'b0;
      end else if (sync) begin
        rem[c]   = eff(mdiv[c]);
        mtick[c] = 1'b0;
        msq[c]   = 1'b0;
      end else if (!en[c]) begin
        mtick[c] = 1'b0;
      end else begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          mtick[c] = 1'b1;
          msq[c]   = ~msq[c];
          rem[c]   = eff(mdiv[c]);
        end else begin
          mtick[c] = 1'b0;
        end
      end
    end
    e.tick = mtick;
    e.sq   = msq;
    e.div  = {mdiv[1], mdiv[0]};
    sb.push_back(e);
  endtask

  // One clock: record expectation, take the edge, compare the outputs.
  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_eq("tick", 64'(tick), 64'(e.tick));
      check_eq("sq", 64'(sq), 64'(e.sq));
      check_eq("div_rd", 64'(div_rd), 64'(e.div));
    end
  endtask

  task automatic idle();
    sync   = 1'b0;
    wr_en  = 1'b0;
    wr_ch  = 1'b0;
    wr_div = 25'd0;
  endtask

  task automatic write(input logic [0:0] ch, input logic [24:0] d);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_div = d;
    step();
    idle();
  endtask

  // Steps until tick[ch] is seen, bounded by limit.
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < limit);
  endtask

  int n;
  int t0;
  int t1;
  logic sq_hold;

  initial begin
    reset   = 1'b0;
    en      = 2'b11;
    en3     = 3'b000;
    sync3   = 1'b0;
    wr_en3  = 1'b0;
    wr_ch3  = 2'd0;
    wr_div3 = 8'd0;
    idle();
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    phase = "reset";
    check_eq("tick", 64'(tick), 64'd0);
    check_eq("sq", 64'(sq), 64'd0);
    check_eq("div_rd", 64'(div_rd), 64'(INIT));
    check_eq("div_rd3", 64'(div_rd3), 64'(INIT3));
    reset = 1'b0;
    model_reset();

    phase = "defaults";
    wait_tick(0, 10, n);
    check_eq("first_tick0", 64'(n), 64'd2);
    for (int k = 0; k < 12; k++) step();

    phase = "wr5";
    step();
    write(1'b0, 25'd5);
    check_eq("div0", 64'(div_rd[24:0]), 64'd5);
    wait_tick(0, 20, n);
    check_eq("first_tick0", 64'(n), 64'd5);
    wait_tick(0, 20, n);
    check_eq("period0", 64'(n), 64'd5);
    for (int k = 0; k < 10; k++) step();

    phase = "wr0_wr1";
    write(1'b0, 25'd0);
    check_eq("tick0_after_wr0", 64'(tick[0]), 64'd0);
    step();
    check_eq("tick0_2nd_after_wr0", 64'(tick[0]), 64'd1);
    write(1'b0, 25'd1);
    check_eq("tick0_after_wr1", 64'(tick[0]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("tick0_stuck", 64'(tick[0]), 64'd1);
    end

    phase = "enable";
    write(1'b0, 25'd3);
    step();
    sq_hold = sq[0];
    en = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("tick0_off", 64'(tick[0]), 64'd0);
    end
    check_eq("sq0_frozen", 64'(sq[0]), 64'(sq_hold));
    en = 2'b11;
    wait_tick(0, 10, n);
    check_eq("resume_tick0", 64'(n), 64'd2);

    phase = "sync";
    write(1'b1, 25'd7);
    for (int k = 0; k < 9; k++) step();
    sync = 1'b1;
    step();
    idle();
    check_eq("sq_after_sync", 64'(sq), 64'd0);
    t0 = -1;
    t1 = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick[0] && t0 < 0) t0 = k;
      if (tick[1] && t1 < 0) t1 = k;
    end
    check_eq("sync_tick0", 64'(t0), 64'd3);
    check_eq("sync_tick1", 64'(t1), 64'd7);

    phase = "sync_wr";
    for (int k = 0; k < 3; k++) step();
    sq_hold = sq[1];
    sync   = 1'b1;
    wr_en  = 1'b1;
    wr_ch  = 1'b1;
    wr_div = 25'd4;
    step();
    idle();
    check_eq("sq1_held", 64'(sq[1]), 64'(sq_hold));
    check_eq("sq0_cleared", 64'(sq[0]), 64'd0);
    check_eq("div1", 64'(div_rd[49:25]), 64'd4);
    for (int k = 0; k < 10; k++) step();

    phase = "out_of_range";
    wr_en3  = 1'b1;
    wr_ch3  = 2'd3;
    wr_div3 = 8'd9;
    step();
    check_eq("div_rd3_unchanged", 64'(div_rd3), 64'(INIT3));
    wr_ch3 = 2'd2;
    step();
    wr_en3 = 1'b0;
    check_eq("div_rd3_ch2", 64'(div_rd3), 64'({8'd9, 8'd3, 8'd2}));

    phase = "async_reset";
    write(1'b0, 25'd1);
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    #1;
    check_eq("tick", 64'(tick), 64'd0);
    check_eq("sq", 64'(sq), 64'd0);
    check_eq("div_rd", 64'(div_rd), 64'(INIT));
    check_eq("div_rd3", 64'(div_rd3), 64'(INIT3));
    reset = 1'b0;
    model_reset();
    wait_tick(0, 10, n);
    check_eq("first_tick0", 64'(n), 64'd2);
    for (int k = 0; k < 8; k++) step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
